// File: rtl/wallace_div_if.sv
// Handshake and operand/result bundle for the wallace_div sequential divider.
interface wallace_div_if #(
  parameter int WIDTH = 1032,
  parameter int DW    = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [DW-1:0]    divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [DW-1:0]    r;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, q, r, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, q, r, dbz
  );
endinterface

// File: rtl/wallace_div.sv
// Radix-2 restoring divider: WIDTH-bit dividend by DW-bit divisor, one quotient
// bit per clock MSB first, behind a start/done handshake.
module wallace_div #(
  parameter int WIDTH = 1032,
  parameter int DW    = 8
) (
  input logic          clk,
  input logic          rst,
  wallace_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] qd, qd_nx, q_reg;
  logic [DW-1:0]    rem, rem_nx, dv, r_reg;
  logic             dbz_reg;
  logic [CW-1:0]    cnt;
  logic [DW:0]      t;
  logic             ge, last, zero_div;

  always_comb begin
    t        = {rem, qd[WIDTH-1]};
    ge       = (t >= {1'b0, dv});
    rem_nx   = ge ? DW'(t - {1'b0, dv}) : t[DW-1:0];
    qd_nx    = {qd[WIDTH-2:0], ge};
    last     = (cnt == CW'(WIDTH - 1));
    zero_div = (bus.divisor == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = zero_div ? DONE : RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
    bus.q    = q_reg;
    bus.r    = r_reg;
    bus.dbz  = dbz_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qd      <= '0;
      rem     <= '0;
      dv      <= '0;
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          if (zero_div) begin
            q_reg   <= '0;
            r_reg   <= '0;
            dbz_reg <= 1'b1;
          end else begin
            qd  <= bus.dividend;
            rem <= '0;
            dv  <= bus.divisor;
            cnt <= '0;
          end
        end
        RUN: begin
          qd  <= qd_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          // dbz clears with the result commit so all three outputs hold through RUN
          if (last) begin
            q_reg   <= qd_nx;
            r_reg   <= rem_nx;
            dbz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wallace_div.sv
// Scoreboarded random test of wallace_div against a plain-arithmetic division model.
module tb_wallace_div;
  localparam int WIDTH = 1032;
  localparam int DW    = 8;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [DW-1:0]    r;
    logic             dbz;
    int               acc;
    int               lat;
    int               nbusy;
    bit               chk_gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  int   prev_done = 0;
  exp_t sb[$];

  wallace_div_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

  wallace_div #(.WIDTH(WIDTH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] bw;
    bw = WIDTH'(b);
    e.acc = 0;
    e.chk_gap = 1'b0;
    if (b == 0) begin
      e.q = '0; e.r = '0; e.dbz = 1'b1; e.lat = 0; e.nbusy = 0;
    end else begin
      e.q = a / bw; e.r = DW'(a % bw); e.dbz = 1'b0; e.lat = WIDTH; e.nbusy = WIDTH;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      chk("busy_and_done", WIDTH'(bus.busy && bus.done), '0);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done got done=1 exp no pending op at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("q", bus.q, e.q);
          chk("r", WIDTH'(bus.r), WIDTH'(e.r));
          chk("dbz", WIDTH'(bus.dbz), WIDTH'(e.dbz));
          chk("latency", WIDTH'(cyc - e.acc), WIDTH'(e.lat));
          chk("busy_cycles", WIDTH'(busy_cnt), WIDTH'(e.nbusy));
          if (e.chk_gap) chk("done_spacing", WIDTH'(cyc - prev_done), WIDTH'(WIDTH + 2));
        end
        prev_done = cyc;
        busy_cnt = 0;
      end
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    e = model(a, b);
    e.acc = cyc;
    sb.push_back(e);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3 * WIDTH) begin
      @(posedge clk); n++;
    end
    if (sb.size() != 0) begin
      checks++; fails++;
      $display("FAIL done_timeout got %0d pending exp 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, WIDTH'(bus.busy), '0);
    chk({tag, "_done"}, WIDTH'(bus.done), '0);
    chk({tag, "_q"}, bus.q, '0);
    chk({tag, "_r"}, WIDTH'(bus.r), '0);
    chk({tag, "_dbz"}, WIDTH'(bus.dbz), '0);
  endtask

  initial begin
    logic [WIDTH-1:0] x, dvd;
    logic [DW-1:0]    y, c;
    exp_t             e;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(WIDTH'(100), 8'd7);
    drain();
    run_op('1, 8'd255);
    drain();
    run_op(WIDTH'(12345), 8'd0);
    drain();
    run_op(WIDTH'(9), 8'd3);
    drain();

    // second start mid-RUN must be ignored
    run_op(WIDTH'(1000), 8'd9);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.dividend = WIDTH'(50); bus.divisor = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();
    repeat (WIDTH + 4) @(posedge clk);
    #1;

    // reset aborts an operation in flight
    run_op(WIDTH'(1000), 8'd9);
    repeat (499) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("abort");
    sb.delete();
    rst = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    run_op(WIDTH'(255), 8'd16);
    drain();

    // back-to-back operations with start held high
    bus.start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      x = '0;
      for (int i = 0; i < 32; i++) x[i*32 +: 32] = $urandom;
      y = DW'($urandom_range(1, 255));
      c = (k % 2 == 0) ? '0 : DW'($urandom_range(0, int'(y) - 1));
      dvd = x * WIDTH'(y) + WIDTH'(c);
      bus.dividend = dvd; bus.divisor = y;
      @(posedge clk); #1;
      e.q = x; e.r = c; e.dbz = 1'b0; e.acc = cyc; e.lat = WIDTH; e.nbusy = WIDTH;
      e.chk_gap = (k > 0);
      sb.push_back(e);
      if (k == 49) bus.start = 1'b0;
      else begin
        repeat (WIDTH + 1) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
